// File: rtl/cdb_fub_arbiter_if.sv
// FU-side push ports, branch resolution inputs and the two-lane CDB
// grouped as one bundle between the functional units and the arbiter.
interface cdb_fub_arbiter_if #(
  parameter int NUM_FU = 8,
  parameter int PRW = 6,
  parameter int DW = 64,
  parameter int BMW = 4,
  parameter int BSPW = 2
);
  logic [NUM_FU-1:0] fu_valid;
  logic [NUM_FU-1:0][PRW-1:0] fu_tagDest;
  logic [NUM_FU-1:0][DW-1:0] fu_result;
  logic [NUM_FU-1:0][BMW-1:0] fu_bmask;
  logic [NUM_FU-1:0] fu_ready;
  logic br_pred_wrong;
  logic br_pred_correct;
  logic [BSPW-1:0] br_bs_ptr;
  logic [1:0] cdb_rd_en;
  logic [1:0][PRW-1:0] cdb_rd;
  logic [1:0][DW-1:0] cdb_reg_value;

  modport master (
    output fu_valid, fu_tagDest, fu_result,
    output fu_bmask, br_pred_wrong,
    output br_pred_correct, br_bs_ptr,
    input fu_ready, cdb_rd_en, cdb_rd,
    input cdb_reg_value
  );

  modport slave (
    input fu_valid, fu_tagDest, fu_result,
    input fu_bmask, br_pred_wrong,
    input br_pred_correct, br_bs_ptr,
    output fu_ready, cdb_rd_en, cdb_rd,
    output cdb_reg_value
  );
endinterface

// File: rtl/cdb_fub_arbiter.sv
// Per-FU result buffers feeding a two-lane CDB with fixed priority,
// an age-based starvation override and branch squash/clear.
module cdb_fub_arbiter #(
  parameter int NUM_FU = 8,
  parameter int QD = 2,
  parameter int PRW = 6,
  parameter int DW = 64,
  parameter int BMW = 4,
  parameter int BSPW = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clock,
  input logic reset,
  cdb_fub_arbiter_if.slave bus
);
  localparam int CW = $clog2(QD + 1);
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam int IW = $clog2(NUM_FU);
  localparam logic [PRW-1:0] PHYS_ZERO_REG = '0;

  typedef struct packed {
    logic [BMW-1:0] bm;
    logic [PRW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q [NUM_FU][QD];
  ent_t q_n [NUM_FU][QD];
  logic [CW-1:0] cnt [NUM_FU];
  logic [CW-1:0] cnt_n [NUM_FU];
  logic [AW-1:0] age [NUM_FU];
  logic [AW-1:0] age_n [NUM_FU];

  logic wrong;
  logic clr;
  logic [NUM_FU-1:0] elig;
  logic [NUM_FU-1:0] starved;
  logic [NUM_FU-1:0] pop;
  logic v0;
  logic v1;
  logic [IW-1:0] s0;
  logic [IW-1:0] s1;

  // A mispredict overrides a simultaneous correct prediction.
  assign wrong = bus.br_pred_wrong;
  assign clr = bus.br_pred_correct & ~wrong;

  always_comb begin
    elig = '0;
    starved = '0;
    bus.fu_ready = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      elig[i] = (cnt[i] != '0) &&
        !(wrong && q[i][0].bm[bus.br_bs_ptr]);
      starved[i] = elig[i] &&
        (age[i] >= AW'(STARVE_LIMIT));
      bus.fu_ready[i] = cnt[i] < CW'(QD);
    end
  end

  // Pass 0 takes starved heads, pass 1 the rest.
  always_comb begin
    v0 = 1'b0;
    v1 = 1'b0;
    s0 = '0;
    s1 = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (elig[i] && (starved[i] == (p == 0))) begin
          if (!v0) begin
            v0 = 1'b1;
            s0 = IW'(i);
          end else if (!v1) begin
            v1 = 1'b1;
            s1 = IW'(i);
          end
        end
      end
    end
    pop = '0;
    if (v0) pop[s0] = 1'b1;
    if (v1) pop[s1] = 1'b1;
  end

  always_comb begin : p_next
    int k;
    ent_t e;
    logic hk;
    k = 0;
    e = '0;
    hk = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      k = 0;
      for (int j = 0; j < QD; j++) q_n[i][j] = q[i][j];
      for (int j = 0; j < QD; j++) begin
        e = q[i][j];
        if ((CW'(j) < cnt[i]) &&
            !(j == 0 && pop[i]) &&
            !(wrong && e.bm[bus.br_bs_ptr])) begin
          if (clr) e.bm[bus.br_bs_ptr] = 1'b0;
          for (int m = 0; m < QD; m++)
            if (m == k) q_n[i][m] = e;
          k++;
        end
      end
      e.bm = bus.fu_bmask[i];
      e.tag = bus.fu_tagDest[i];
      e.data = bus.fu_result[i];
      if (clr) e.bm[bus.br_bs_ptr] = 1'b0;
      if (bus.fu_valid[i] && bus.fu_ready[i] &&
          !(wrong && bus.fu_bmask[i][bus.br_bs_ptr])) begin
        for (int m = 0; m < QD; m++)
          if (m == k) q_n[i][m] = e;
        k++;
      end
      cnt_n[i] = CW'(k);
      hk = (cnt[i] != '0) && !pop[i] &&
        !(wrong && q[i][0].bm[bus.br_bs_ptr]);
      if (!hk)
        age_n[i] = '0;
      else if (age[i] == AW'(STARVE_LIMIT))
        age_n[i] = age[i];
      else
        age_n[i] = age[i] + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        cnt[i] <= '0;
        age[i] <= '0;
        for (int j = 0; j < QD; j++) q[i][j] <= '0;
      end
      bus.cdb_rd_en <= '0;
      bus.cdb_rd[0] <= PHYS_ZERO_REG;
      bus.cdb_rd[1] <= PHYS_ZERO_REG;
      bus.cdb_reg_value <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        cnt[i] <= cnt_n[i];
        age[i] <= age_n[i];
        for (int j = 0; j < QD; j++) q[i][j] <= q_n[i][j];
      end
      bus.cdb_rd_en <= {v1, v0};
      bus.cdb_rd[0] <= v0 ? q[s0][0].tag : PHYS_ZERO_REG;
      bus.cdb_rd[1] <= v1 ? q[s1][0].tag : PHYS_ZERO_REG;
      bus.cdb_reg_value[0] <= v0 ? q[s0][0].data : '0;
      bus.cdb_reg_value[1] <= v1 ? q[s1][0].data : '0;
    end
  end
endmodule

// File: tb/tb_cdb_fub_arbiter.sv
// Bench for cdb_fub_arbiter: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_cdb_fub_arbiter;
  localparam int N = 8;
  localparam int PRW = 6;
  localparam int DW = 64;
  localparam int BMW = 4;
  localparam int BSPW = 2;
  localparam int LIM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cdb_fub_arbiter_if #(
    .NUM_FU(N), .PRW(PRW), .DW(DW),
    .BMW(BMW), .BSPW(BSPW)
  ) bus ();

  cdb_fub_arbiter #(
    .NUM_FU(N), .QD(2), .PRW(PRW), .DW(DW),
    .BMW(BMW), .BSPW(BSPW), .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [PRW-1:0] tag;
    logic [DW-1:0] data;
    logic [BMW-1:0] bm;
    int id;
  } ment_t;

  ment_t mq [N][$];
  int mage [N];
  int mhead [N];
  int next_id;
  logic [1:0] x_en;
  logic [1:0][PRW-1:0] x_rd;
  logic [1:0][DW-1:0] x_val;
  logic [N-1:0] x_rdy;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      mage[i] = 0;
      mhead[i] = -1;
    end
    next_id = 0;
  endtask

  // Oldest-first per FU; starved heads are taken before the others.
  task automatic model_step();
    bit w;
    bit c;
    int p;
    int hid;
    bit rdy;
    int pick[$];
    ment_t keep[$];
    ment_t e;
    w = bus.br_pred_wrong;
    c = bus.br_pred_correct && !w;
    p = int'(bus.br_bs_ptr);
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < N; i++)
        if (mq[i].size() > 0 && !(w && mq[i][0].bm[p]) &&
            ((mage[i] >= LIM) == (pass == 0)) &&
            pick.size() < 2)
          pick.push_back(i);
    x_en = '0;
    x_rd = '0;
    x_val = '0;
    for (int l = 0; l < pick.size(); l++) begin
      x_en[l] = 1'b1;
      x_rd[l] = mq[pick[l]][0].tag;
      x_val[l] = mq[pick[l]][0].data;
    end
    for (int i = 0; i < N; i++) begin
      rdy = mq[i].size() < 2;
      for (int l = 0; l < pick.size(); l++)
        if (pick[l] == i) mq[i].delete(0);
      keep.delete();
      for (int j = 0; j < mq[i].size(); j++) begin
        e = mq[i][j];
        if (!(w && e.bm[p])) begin
          if (c) e.bm[p] = 1'b0;
          keep.push_back(e);
        end
      end
      mq[i] = keep;
      if (bus.fu_valid[i] && rdy &&
          !(w && bus.fu_bmask[i][p])) begin
        e.tag = bus.fu_tagDest[i];
        e.data = bus.fu_result[i];
        e.bm = bus.fu_bmask[i];
        if (c) e.bm[p] = 1'b0;
        e.id = next_id;
        next_id++;
        mq[i].push_back(e);
      end
      hid = (mq[i].size() > 0) ? mq[i][0].id : -1;
      if (hid >= 0 && hid == mhead[i])
        mage[i] = (mage[i] < LIM) ? mage[i] + 1 : LIM;
      else
        mage[i] = 0;
      mhead[i] = hid;
      x_rdy[i] = mq[i].size() < 2;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    chk("rd_en", 128'(bus.cdb_rd_en), 128'(x_en));
    chk("rd", 128'(bus.cdb_rd), 128'(x_rd));
    chk("value", 128'(bus.cdb_reg_value), 128'(x_val));
    chk("ready", 128'(bus.fu_ready), 128'(x_rdy));
    @(negedge clock);
  endtask

  task automatic idle();
    bus.fu_valid = '0;
    bus.br_pred_wrong = 1'b0;
    bus.br_pred_correct = 1'b0;
    bus.br_bs_ptr = '0;
  endtask

  task automatic push(int i, logic [PRW-1:0] t,
                      logic [DW-1:0] d, logic [BMW-1:0] b);
    bus.fu_valid[i] = 1'b1;
    bus.fu_tagDest[i] = t;
    bus.fu_result[i] = d;
    bus.fu_bmask[i] = b;
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_ready"}, 128'(bus.fu_ready), 128'(8'hff));
    chk({tag, "_en"}, 128'(bus.cdb_rd_en), 128'(0));
    chk({tag, "_rd"}, 128'(bus.cdb_rd), 128'(0));
    chk({tag, "_val"}, 128'(bus.cdb_reg_value), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.fu_tagDest = '0;
    bus.fu_result = '0;
    bus.fu_bmask = '0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_state("reset");

    // Three-FU contention
    push(0, 6'd5, 64'hA, 4'b0);
    push(3, 6'd9, 64'hB, 4'b0);
    push(7, 6'd12, 64'hC, 4'b0);
    cycle();
    idle();
    cycle();
    chk("t2_l0_rd", 128'(bus.cdb_rd[0]), 128'(5));
    chk("t2_l1_rd", 128'(bus.cdb_rd[1]), 128'(9));
    chk("t2_l0_val", 128'(bus.cdb_reg_value[0]), 128'(64'hA));
    chk("t2_l1_val", 128'(bus.cdb_reg_value[1]), 128'(64'hB));
    cycle();
    chk("t2_l0_rd2", 128'(bus.cdb_rd[0]), 128'(12));
    chk("t2_l0_val2", 128'(bus.cdb_reg_value[0]), 128'(64'hC));
    chk("t2_en2", 128'(bus.cdb_rd_en), 128'(2'b01));
    repeat (2) cycle();

    // Starvation override
    for (int k = 0; k < 6; k++) begin
      idle();
      push(0, 6'd1, 64'(k), 4'b0);
      push(1, 6'd2, 64'(k + 100), 4'b0);
      if (k == 0) push(6, 6'd33, 64'h66, 4'b0);
      cycle();
    end
    chk("t3_l0_rd", 128'(bus.cdb_rd[0]), 128'(33));
    chk("t3_l1_rd", 128'(bus.cdb_rd[1]), 128'(1));
    idle();
    repeat (4) cycle();

    // Mispredict squash
    push(2, 6'd20, 64'h22, 4'b0010);
    push(4, 6'd40, 64'h44, 4'b0001);
    cycle();
    idle();
    bus.br_pred_wrong = 1'b1;
    bus.br_bs_ptr = 2'd1;
    cycle();
    chk("t4_l0_rd", 128'(bus.cdb_rd[0]), 128'(40));
    chk("t4_en", 128'(bus.cdb_rd_en), 128'(2'b01));
    chk("t4_ready2", 128'(bus.fu_ready[2]), 128'(1));
    idle();
    repeat (2) cycle();

    // Correct-predict clear, then mispredict on same bit
    push(0, 6'd3, 64'h3, 4'b0);
    push(1, 6'd4, 64'h4, 4'b0);
    push(3, 6'd30, 64'h33, 4'b0110);
    cycle();
    idle();
    push(0, 6'd5, 64'h5, 4'b0);
    push(1, 6'd6, 64'h6, 4'b0);
    bus.br_pred_correct = 1'b1;
    bus.br_bs_ptr = 2'd2;
    cycle();
    idle();
    bus.br_pred_wrong = 1'b1;
    bus.br_bs_ptr = 2'd2;
    cycle();
    idle();
    cycle();
    chk("t5_l0_rd", 128'(bus.cdb_rd[0]), 128'(30));
    chk("t5_l0_val", 128'(bus.cdb_reg_value[0]), 128'(64'h33));
    repeat (2) cycle();

    // Full queue on FU5
    for (int k = 0; k < 3; k++) begin
      idle();
      push(0, 6'd7, 64'(k), 4'b0);
      push(1, 6'd8, 64'(k), 4'b0);
      push(5, 6'(50 + k), 64'(8'h51 + k), 4'b0);
      cycle();
      if (k == 1)
        chk("t6_ready5", 128'(bus.fu_ready[5]), 128'(0));
    end
    idle();
    cycle();
    cycle();
    chk("t6_first", 128'(bus.cdb_rd[0]), 128'(50));
    cycle();
    chk("t6_second", 128'(bus.cdb_rd[0]), 128'(51));
    repeat (2) cycle();

    // Random traffic, a mid-run reset, more random traffic
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 250; k++) begin
        bus.fu_valid = N'($urandom) & N'($urandom);
        for (int i = 0; i < N; i++) begin
          bus.fu_tagDest[i] = PRW'($urandom);
          bus.fu_result[i] = {$urandom, $urandom};
          bus.fu_bmask[i] = BMW'($urandom);
        end
        bus.br_pred_wrong = ($urandom_range(0, 7) == 0);
        bus.br_pred_correct = ($urandom_range(0, 5) == 0);
        bus.br_bs_ptr = BSPW'($urandom);
        cycle();
      end
      if (r == 0) begin
        idle();
        reset = 1'b0;
        #1;
        model_reset();
        chk_reset_state("midreset");
        @(negedge clock);
        reset = 1'b1;
      end
    end
    idle();
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cdb_fub_arbiter.md
Name: cdb_fub_arbiter

Overview:
- Owns the eight Functional Unit Buffers (FUBs) that feed the two-wide CDB.
- Each FU pushes its completed result into a private 2-entry queue.
- Each cycle the arbiter picks up to two queue heads and drives them onto the CDB from registered outputs.
- Priority is fixed BR -> LD/ST -> MULT -> ALU (lowest index first), plus an age-based anti-starvation override.
- Enforces branch-mask squash and branch-mask clearing while results wait, so FUs never see a `cdb_stall`-style back-pressure except through `fu_ready`.

Parameters:
- NUM_FU, 8, number of functional units; index 0 is highest fixed priority.
- QD, 2, entries per FU queue.
- PRW, 6, physical register tag width (PHYS_REG).
- DW, 64, result width (DATA).
- BMW, 4, branch mask width (B_MASK).
- BSPW, 2, branch stack pointer width (BS_PTR).
- STARVE_LIMIT, 4, head wait cycles after which the head becomes "starved".

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fu_valid  in  NUM_FU  FU i presents a result this cycle.
- fu_tagDest  in  NUM_FU x PRW  destination physical register.
- fu_result  in  NUM_FU x DW  result data.
- fu_bmask  in  NUM_FU x BMW  branch mask of the producing instruction.
- fu_ready  out  NUM_FU  queue i can accept (count_i < QD).
- br_pred_wrong  in  1  mispredict resolved this cycle.
- br_pred_correct  in  1  correct prediction resolved this cycle.
- br_bs_ptr  in  BSPW  branch stack index being resolved.
- cdb_rd_en  out  2  CDB lane valid.
- cdb_rd  out  2 x PRW  CDB lane tag.
- cdb_reg_value  out  2 x DW  CDB lane data.

Behaviour:
- Reset (async, reset=0):
  - all queues empty; all head ages 0; `fu_ready` = all 1.
  - `cdb_rd_en` = 0; `cdb_rd` = `PHYS_ZERO_REG` on both lanes; `cdb_reg_value` = 0.
  - A reset mid-operation discards all buffered results.
- `fu_ready[i]` is a function of registered count only; it is not raised by a same-cycle dequeue.
- Enqueue happens at the clock edge when `fu_valid[i] & fu_ready[i]`.
  - Dropped if `br_pred_wrong` and `fu_bmask[i][br_bs_ptr]`.
  - If `br_pred_correct`, stored bmask has bit `br_bs_ptr` cleared.
  - Asserting `fu_valid` while `fu_ready` = 0 is a protocol error; the input is ignored.
- Squash: on `br_pred_wrong`, every queued entry with `bmask[br_bs_ptr]` = 1 is invalidated the same edge.
  - Queues compact, so surviving entries keep order.
  - Squashed heads are ineligible for selection that cycle.
- Clear: on `br_pred_correct`, bit `br_bs_ptr` is cleared in every queued bmask.
- If both branch inputs are asserted, treat the cycle as `br_pred_wrong` only.
- Eligibility: head of queue i is valid and not squashed this cycle.
- Selection, lane 0 then lane 1, always two distinct FUs, at most one entry per FU per cycle:
  1. Starved eligible heads (age >= STARVE_LIMIT), lowest index first.
  2. Then the remaining eligible heads, lowest index first.
- Lane 0 is always filled before lane 1.
- Selected heads pop at the edge; the selected tag and data load into the `cdb_*` output registers.
- An unused lane loads `rd_en` = 0, `rd` = `PHYS_ZERO_REG`, value 0.
- Latency: a result enqueued at edge N is eligible in cycle N+1 and appears on `cdb_*` after edge N+1 at the earliest (2 edges from `fu_valid` sampled).
- Once latched into the `cdb_*` outputs, a result is not squashed; `br_pred_wrong` only affects queued entries and same-cycle selection.
- Head age:
  - increments, saturating at STARVE_LIMIT, each cycle the head is valid and not selected;
  - resets to 0 on pop, on squash, or when a new entry becomes head.
- Simultaneous enqueue and dequeue on a full queue: the pop happens, but the enqueue is not accepted (ready was 0).
- Simultaneous enqueue and dequeue on a non-full queue: both occur and count is unchanged.
- Throughput: at most 2 results per cycle in total; each FU sustains 1 per cycle only if granted every cycle.

Test Plan:
1. Reset with all inputs 0, then release → `fu_ready` = 8'hff, `cdb_rd_en` = 0, `cdb_rd` = `PHYS_ZERO_REG`, values 0.
2. Three-FU contention: FU0 (tag 5, 0xA), FU3 (tag 9, 0xB) and FU7 (tag 12, 0xC) valid at edge 0 → after edge 1, lane0 = tag 5 / 0xA and lane1 = tag 9 / 0xB; after edge 2, lane0 = tag 12 / 0xC and lane1 `rd_en` = 0.
3. Starvation: FU0 and FU1 push every cycle and FU6 holds one entry → by its 5th wait cycle (age 4) FU6 takes lane0, FU0 takes lane1, and FU1 waits.
4. Mispredict squash: FU2 has queued bmask 4'b0010 and FU4 has 4'b0001; `br_pred_wrong` with `br_bs_ptr` = 1 → FU2's entry never reaches the CDB, FU4's does, and FU2 `fu_ready` = 1 the next cycle.
5. Correct-predict clear: entry with bmask 4'b0110; `br_pred_correct` with ptr 2, then `br_pred_wrong` with ptr 2 → entry survives and broadcasts.
6. Full queue: FU5 valid for 3 consecutive cycles while never granted → `fu_ready[5]` = 0 after 2 accepts, and the 3rd input is ignored; data order is preserved on release.
